// File: rtl/uart_byte_sender.sv
// Byte-change UART transmitter: serializes each new value seen on data, 8N1, LSB first.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_byte_sender #(
    parameter int unsigned BAUD_DIV = 104,
    parameter int unsigned CW       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       pend
);

    localparam int unsigned BW      = 8;
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [BW-1:0]   shift_q, shift_d;
    logic [BW-1:0]   prev_q, prev_d;
    logic [BW-1:0]   pbyte_q, pbyte_d;
    logic            pend_d, tx_d, busy_d;
    logic            tick, load;
`ifdef UART_PARITY_EN
    logic            par_q, par_d;
`endif

    assign tick = (cnt_q == CNT_MAX);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            prev_q  <= '0;
            pbyte_q <= '0;
            pend    <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
            pbyte_q <= pbyte_d;
            pend    <= pend_d;
            tx      <= tx_d;
            busy    <= busy_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state, baud timing, change detect and line level
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        prev_d  = prev_q;
        pbyte_d = pbyte_q;
        pend_d  = pend;
        busy_d  = busy;
        tx_d    = 1'b1;
        load    = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                load = pend;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (pend) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shift_d = pbyte_q;
            pend_d  = 1'b0;
            state_d = START;
            busy_d  = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
`ifdef UART_PARITY_EN
            par_d   = ^pbyte_q;
`endif
        end

        // A change on the same edge as a load wins: the new byte stays pending
        if (data != prev_q) begin
            prev_d  = data;
            pbyte_d = data;
            pend_d  = 1'b1;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
`ifdef UART_PARITY_EN
        if (load && state_d == START) begin
            tx_d = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_uart_byte_sender.sv
// Scoreboard bench for uart_byte_sender: stimulus pushes expected bytes, a line monitor decodes tx.
module tb_uart_byte_sender;

    localparam int unsigned B = 4;
`ifdef UART_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       tx, busy, pend;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    uart_byte_sender #(.BAUD_DIV(B), .CW(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .tx   (tx),
        .busy (busy),
        .pend (pend)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            step(1);
            n++;
        end
        check("busy_drop", 32'(busy), 32'd0);
    endtask

    // Line monitor: decode each frame and compare against the scoreboard
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] want;
        logic       stop_bit, par_bit, bad, aborted, s;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                starts.push_back(cyc);
                aborted = 1'b0; bad = 1'b0; got = '0;
                stop_bit = 1'b0; par_bit = 1'b0; s = 1'b0;
                for (int i = 0; i < int'(FB) && !aborted; i++) begin
                    for (int j = 0; j < int'(B); j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (busy !== 1'b1) bad = 1'b1;
                        if (j == 0) s = tx;
                        else if (tx !== s) bad = 1'b1;
                    end
                    if (!aborted) begin
                        if (i == 0 && s !== 1'b0) bad = 1'b1;
                        else if (i >= 1 && i <= 8) got[i-1] = s;
                        else if (i == 9 && FB == 11) par_bit = s;
                        else if (i == int'(FB) - 1) stop_bit = s;
                    end
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got byte %0h expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (!aborted) begin
                        check("frame_byte", 32'(got), 32'(want));
                        check("frame_format", 32'({bad, stop_bit, par_bit}),
                              32'({1'b0, 1'b1, (FB == 11) ? ^want : 1'b0}));
                    end
                end
            end
        end
    end

    initial begin : stim
        int n;
        int ns;
        logic flag;

        // Test 1: reset and quiet idle
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("reset_outputs", 32'({tx, busy, pend}), 32'b100);
        end
        rst = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if ({tx, busy, pend} !== 3'b100) flag = 1'b1;
        end
        check("idle_after_reset", 32'(flag), 32'd0);

        // Test 2: single byte, latency and frame length
        data = 8'hA5; exp_q.push_back(8'hA5);
        step(1);
        check("pend_after_change", 32'({tx, busy, pend}), 32'b101);
        step(1);
        check("frame_load", 32'({tx, busy, pend}), 32'b010);
        wait_idle(n);
        check("frame_len_a5", 32'(n), 32'(FB * B));
        step(3);

        // Test 3: overwrite during a frame, back-to-back follow-up
        ns = starts.size();
        data = 8'h01; exp_q.push_back(8'h01);
        step(2);
        step(8);
        data = 8'h02;
        step(1);
        check("pend_during_frame", 32'({busy, pend}), 32'b11);
        step(8);
        data = 8'h03; exp_q.push_back(8'h03);
        step(1);
        check("pend_overwrite", 32'({busy, pend}), 32'b11);
        wait_idle(n);
        check("back_to_back_busy", 32'(n), 32'(2 * FB * B - 18));
        check("frames_seen", 32'(starts.size()), 32'(ns + 2));
        if (starts.size() >= ns + 2)
            check("frame_gap", 32'(starts[ns+1] - starts[ns]), 32'(FB * B));
        step(3);

        // Test 4: wrap-around FF -> 00
        data = 8'hFF; exp_q.push_back(8'hFF);
        step(2);
        wait_idle(n);
        check("frame_len_ff", 32'(n), 32'(FB * B));
        step(3);
        data = 8'h00; exp_q.push_back(8'h00);
        step(2);
        wait_idle(n);
        check("frame_len_00", 32'(n), 32'(FB * B));
        step(3);

        // Test 5: reset during data bit 3
        data = 8'h3C; exp_q.push_back(8'h3C);
        step(2);
        step(17);
        check("midframe_busy", 32'(busy), 32'd1);
        rst = 1'b1; data = 8'h00;
        step(1);
        check("reset_midframe", 32'({tx, busy, pend}), 32'b100);
        rst = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if ({tx, busy, pend} !== 3'b100) flag = 1'b1;
        end
        check("no_frame_after_reset", 32'(flag), 32'd0);
        data = 8'h5A; exp_q.push_back(8'h5A);
        step(2);
        wait_idle(n);
        check("frame_len_5a", 32'(n), 32'(FB * B));
        step(3);

`ifdef UART_PARITY_EN
        // Test 6: parity bit for 8'h07 is 1, frame is 44 cycles
        data = 8'h07; exp_q.push_back(8'h07);
        step(2);
        wait_idle(n);
        check("parity_frame_len", 32'(n), 32'd44);
        step(3);
`endif

        step(4);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
